// File: rtl/demux1to4_buf.sv
// ============================================================================
//  Module      : demux1to4_buf
//  Description : Registered 1-to-4 demultiplexer. Each incoming word is
//                steered by in_sel into one of four one-entry holding
//                registers, each with its own valid/ready handshake toward
//                its consumer. Fixed one-cycle latency, no in->out data path.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux1to4_buf #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_sel,
    input  logic [N-1:0] in_data,
    output logic [3:0]   out_valid,
    input  logic [3:0]   out_ready,
    output logic [N-1:0] out_data0,
    output logic [N-1:0] out_data1,
    output logic [N-1:0] out_data2,
    output logic [N-1:0] out_data3,
    output logic         busy
);

    localparam int NCH = 4;

    logic [3:0]   valid_q;
    logic [3:0]   valid_d;
    logic [3:0]   load;
    logic [N-1:0] data_q [NCH];
    logic         accept;
    logic         busy_q;

    // Only the addressed channel gates acceptance; a full channel may still
    // take a new word in the same cycle its consumer drains the old one.
    assign in_ready = ~flush & (~valid_q[in_sel] | out_ready[in_sel]);
    assign accept   = in_valid & in_ready;

    // Per-channel load strobes and next-state occupancy.
    always_comb begin
        load    = '0;
        valid_d = valid_q;
        for (int k = 0; k < NCH; k++) begin
            load[k] = accept & (in_sel == k[1:0]);
            if (flush)
                valid_d[k] = 1'b0;
            else if (load[k])
                valid_d[k] = 1'b1;
            else if (valid_q[k] & out_ready[k])
                valid_d[k] = 1'b0;
        end
    end

    // Occupancy flags and the registered busy summary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            busy_q  <= |valid_d;
        end
    end

    generate
        for (genvar g = 0; g < NCH; g++) begin : g_ch
            // Data register only moves on a load; flush leaves the value alone.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    data_q[g] <= '0;
                else if (load[g])
                    data_q[g] <= in_data;
            end
        end
    endgenerate

    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign out_data0 = data_q[0];
    assign out_data1 = data_q[1];
    assign out_data2 = data_q[2];
    assign out_data3 = data_q[3];

endmodule

`default_nettype wire

// File: tb/tb_demux1to4_buf.sv
// ============================================================================
//  Module      : tb_demux1to4_buf
//  Description : Self-checking bench for demux1to4_buf with directed
//                scenarios and a randomized run against per-channel queues.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux1to4_buf;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_sel;
    logic [N-1:0] in_data;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
    logic [N-1:0] out_data0, out_data1, out_data2, out_data3;
    logic         busy;
    logic [N-1:0] od [4];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign od[0] = out_data0;
    assign od[1] = out_data1;
    assign od[2] = out_data2;
    assign od[3] = out_data3;

    demux1to4_buf #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data0(out_data0), .out_data1(out_data1),
        .out_data2(out_data2), .out_data3(out_data3),
        .busy(busy)
    );

    // Advance one clock edge; inputs may be changed right after return.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_sel = 2'd0;
        in_data = '0; out_ready = 4'h0;
        #12;
        tests++;
        if (out_valid !== 4'h0) begin fails++; $display("FAIL reset_valid got=%b exp=0000", out_valid); end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (od[k] !== '0) begin fails++; $display("FAIL reset_data%0d got=%h exp=0", k, od[k]); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_routing();
        out_ready = 4'hF;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_sel = k[1:0]; in_data = 32'hA0 + k;
            @(negedge clk);
            tests++;
            if (in_ready !== 1'b1) begin fails++; $display("FAIL route_ready%0d got=%b exp=1", k, in_ready); end
            step();
            in_valid = 1'b0;
            tests++;
            if (out_valid !== (4'b1 << k) || od[k] !== 32'hA0 + k) begin
                fails++;
                $display("FAIL route_ch%0d valid=%b data=%h exp_valid=%b exp_data=%h",
                         k, out_valid, od[k], 4'b1 << k, 32'hA0 + k);
            end
        end
        step();
        tests++;
        if (out_valid !== 4'h0) begin fails++; $display("FAIL route_drain got=%b exp=0000", out_valid); end
    endtask

    task automatic test_stall();
        out_ready = 4'h0;
        in_valid = 1'b1; in_sel = 2'd2; in_data = 32'h55;
        step();
        in_data = 32'h66;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_ready got=%b exp=0", in_ready); end
        step();
        tests++;
        if (out_valid[2] !== 1'b1 || out_data2 !== 32'h55) begin
            fails++; $display("FAIL stall_hold valid=%b data=%h exp=1/55", out_valid[2], out_data2);
        end
        in_sel = 2'd1; in_data = 32'h77;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL stall_other_ready got=%b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 4'b0110 || out_data1 !== 32'h77 || out_data2 !== 32'h55) begin
            fails++;
            $display("FAIL stall_other valid=%b d1=%h d2=%h exp=0110/77/55", out_valid, out_data1, out_data2);
        end
        out_ready = 4'hF;
        step();
        out_ready = 4'h0;
        tests++;
        if (out_valid !== 4'h0) begin fails++; $display("FAIL stall_drain got=%b exp=0000", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 4'h0;
        in_valid = 1'b1; in_sel = 2'd0; in_data = 32'h11;
        step();
        out_ready = 4'h1; in_data = 32'h12;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready got=%b exp=1", in_ready); end
        step();
        in_valid = 1'b0; out_ready = 4'h0;
        tests++;
        if (out_valid[0] !== 1'b1 || out_data0 !== 32'h12) begin
            fails++; $display("FAIL b2b_reload valid=%b data=%h exp=1/12", out_valid[0], out_data0);
        end
        out_ready = 4'hF;
        step();
        out_ready = 4'h0;
        tests++;
        if (out_valid !== 4'h0) begin fails++; $display("FAIL b2b_drain got=%b exp=0000", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 4'h0;
        in_valid = 1'b1; in_sel = 2'd1; in_data = 32'h31;
        step();
        in_sel = 2'd3; in_data = 32'h33;
        step();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 4'b1010 || busy !== 1'b1) begin
            fails++; $display("FAIL flush_pre valid=%b busy=%b exp=1010/1", out_valid, busy);
        end
        flush = 1'b1; in_valid = 1'b1; in_sel = 2'd0; in_data = 32'h99;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_ready got=%b exp=0", in_ready); end
        step();
        flush = 1'b0; in_valid = 1'b0;
        tests++;
        if (out_valid !== 4'h0 || busy !== 1'b0) begin
            fails++; $display("FAIL flush_clear valid=%b busy=%b exp=0000/0", out_valid, busy);
        end
        tests++;
        if (out_data0 !== 32'h12 || out_data1 !== 32'h31) begin
            fails++; $display("FAIL flush_data d0=%h d1=%h exp=12/31", out_data0, out_data1);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] q [4][$];
        logic [N-1:0] last [4];
        logic [3:0]   exp_valid;
        logic         exp_ready;
        last[0] = 32'h12; last[1] = 32'h31; last[2] = 32'h55; last[3] = 32'h33;
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sel    = 2'($urandom_range(0, 3));
            in_data   = $urandom;
            out_ready = 4'($urandom);
            flush     = ($urandom_range(0, 63) == 0);
            @(negedge clk);
            for (int k = 0; k < 4; k++) exp_valid[k] = (q[k].size() != 0);
            exp_ready = !flush && (q[in_sel].size() == 0 || out_ready[in_sel]);
            tests++;
            if (in_ready !== exp_ready) begin
                fails++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, in_ready, exp_ready);
            end
            tests++;
            if (out_valid !== exp_valid || busy !== (|exp_valid)) begin
                fails++;
                $display("FAIL rand_valid cyc=%0d valid=%b busy=%b exp=%b/%b", c, out_valid, busy, exp_valid, |exp_valid);
            end
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (od[k] !== last[k]) begin
                    fails++; $display("FAIL rand_data%0d cyc=%0d got=%h exp=%h", k, c, od[k], last[k]);
                end
            end
            if (flush) begin
                for (int k = 0; k < 4; k++) q[k].delete();
            end else begin
                for (int k = 0; k < 4; k++)
                    if (q[k].size() != 0 && out_ready[k]) void'(q[k].pop_front());
                if (in_valid && exp_ready) begin
                    q[in_sel].push_back(in_data);
                    last[in_sel] = in_data;
                end
            end
            step();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 4'h0;
    endtask

    task automatic test_midop_reset();
        out_ready = 4'h0;
        in_valid = 1'b1; in_sel = 2'd2; in_data = 32'hDEAD;
        step();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 4'h0 || busy !== 1'b0 || out_data2 !== '0) begin
            fails++;
            $display("FAIL midop_reset valid=%b busy=%b d2=%h exp=0000/0/0", out_valid, busy, out_data2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_routing();
        test_stall();
        test_back_to_back();
        test_flush();
        test_random();
        test_midop_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
